// File: rtl/si_pif_pkg.sv
// si_pif_pkg: shared types and constants for the PIF serial initiator
package si_pif_pkg;
    localparam logic [1:0] SI_WR64 = 2'd0;
    localparam logic [1:0] SI_RD64 = 2'd1;
    localparam logic [1:0] SI_WR4  = 2'd2;
    localparam logic [1:0] SI_RD4  = 2'd3;
    localparam int CMD_BITS  = 11;
    localparam int WORD_BITS = 32;
    typedef enum logic [2:0] {IDLE, START, CMD, ACK_WAIT, RD_DATA, WR_START, WR_DATA, DONE} si_state_e;
    // Index of the final payload bit: one word for 4-byte types, sixteen otherwise.
    function automatic logic [8:0] last_bit(input logic short_xfer);
        return short_xfer ? 9'(WORD_BITS - 1) : 9'(16 * WORD_BITS - 1);
    endfunction
endpackage

// File: rtl/si_pif_sync2.sv
// si_pif_sync2: two-flop synchroniser for the asynchronous serial line
//   clk, reset_l : clock, async active-low reset (resets to the idle-high level)
//   d            : asynchronous input
//   q            : synchronised output
module si_sync2 (
    input  logic clk,
    input  logic reset_l,
    input  logic d,
    output logic q
);
    logic s1_q, s2_q;
    always_ff @(posedge clk or negedge reset_l)
        if (!reset_l) {s1_q, s2_q} <= 2'b11;
        else          {s1_q, s2_q} <= {d, s1_q};
    assign q = s2_q;
endmodule

// File: rtl/si_pif_master.sv
// si_pif_master: RCP-side PIF serial initiator (request, ack wait, 4/64-byte data phase)
module si_pif_master
  import si_pif_pkg::*;
#(
  parameter int ACK_TIMEOUT = 4095,
  parameter int TO_W        = 12
)
(
  input  logic        clk,
  input  logic        reset_l,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [8:0]  cmd_addr,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic        si_out,
  input  logic        si_in,
  output logic [3:0]  buf_addr,
  output logic        buf_wren,
  output logic [31:0] buf_wdata,
  input  logic [31:0] buf_rdata
);
  si_state_e   state_q, state_d;
  logic [1:0]  type_q, type_d;
  logic [10:0] cmd_q, cmd_d;
  logic [8:0]  bit_q, bit_d;
  logic [30:0] rx_q, rx_d;
  logic [31:0] tx_q, tx_d;
  logic [3:0]  addr_q, addr_d;
  logic        wren_q, wren_d;
  logic [31:0] wdata_q, wdata_d;
  logic        prev_q, si_s, fall, at_end, more_words;

  si_sync2 u_sync (.clk(clk), .reset_l(reset_l), .d(si_in), .q(si_s));

  assign fall       = prev_q & ~si_s;
  assign at_end     = bit_q == last_bit(type_q[1]);
  assign more_words = ~type_q[1] && bit_q[8:5] != 4'hF;

`ifdef SI_TIMEOUT_EN
  logic [TO_W-1:0] to_q, to_d;
  logic            err_q, err_d;
  assign err = state_q == DONE && err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    cmd_d   = cmd_q;
    bit_d   = bit_q + 9'd1;
    rx_d    = rx_q;
    tx_d    = tx_q;
    addr_d  = addr_q;
    wren_d  = 1'b0;
    wdata_d = wdata_q;
`ifdef SI_TIMEOUT_EN
    to_d    = state_q == ACK_WAIT ? to_q + 1'b1 : '0;
    err_d   = state_q == IDLE ? 1'b0 : err_q;
`endif
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = START;
        type_d  = cmd_type;
        cmd_d   = {cmd_type, cmd_addr};
        addr_d  = '0;
      end
      START: begin
        state_d = CMD;
        bit_d   = '0;
      end
      CMD: begin
        cmd_d = {cmd_q[9:0], 1'b0};
        if (bit_q == 9'(CMD_BITS - 1)) state_d = ACK_WAIT;
      end
      ACK_WAIT: if (fall) begin
        addr_d  = '0;
        bit_d   = '0;
        state_d = type_q[0] ? RD_DATA : WR_START;
      end
`ifdef SI_TIMEOUT_EN
      else if (to_q == TO_W'(ACK_TIMEOUT - 1)) begin
        state_d = DONE;
        err_d   = 1'b1;
      end
`endif
      RD_DATA: begin
        rx_d = {rx_q[29:0], si_s};
        if (&bit_q[4:0]) begin
          wren_d  = 1'b1;
          wdata_d = {rx_q, si_s};
          addr_d  = bit_q[8:5];
        end
        if (at_end) state_d = DONE;
      end
      WR_START: begin
        tx_d    = buf_rdata;
        bit_d   = '0;
        state_d = WR_DATA;
      end
      WR_DATA: begin
        tx_d = &bit_q[4:0] ? buf_rdata : {tx_q[30:0], 1'b0};
        if (bit_q[4:0] == 5'd29 && more_words) addr_d = addr_q + 4'd1;
        if (at_end) state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) begin
      state_q <= IDLE;
      type_q  <= '0;
      cmd_q   <= '0;
      bit_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      addr_q  <= '0;
      wren_q  <= 1'b0;
      wdata_q <= '0;
      prev_q  <= 1'b1;
`ifdef SI_TIMEOUT_EN
      to_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      cmd_q   <= cmd_d;
      bit_q   <= bit_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      addr_q  <= addr_d;
      wren_q  <= wren_d;
      wdata_q <= wdata_d;
      prev_q  <= si_s;
`ifdef SI_TIMEOUT_EN
      to_q    <= to_d;
      err_q   <= err_d;
`endif
    end

  assign si_out    = state_q == START || state_q == WR_START ? 1'b0 :
                     state_q == CMD ? cmd_q[10] :
                     state_q == WR_DATA ? tx_q[31] : 1'b1;
  assign cmd_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign buf_addr  = addr_q;
  assign buf_wren  = wren_q;
  assign buf_wdata = wdata_q;
endmodule

// File: tb/tb_si_pif_master.sv
// tb_si_pif_master: scoreboard bench for si_pif_master with a PIF line model and host buffer
module tb_si_pif_master;
  import si_pif_pkg::*;

  logic        clk = 1'b0, reset_l = 1'b0, cmd_valid = 1'b0, si_in = 1'b1;
  logic [1:0]  cmd_type = '0;
  logic [8:0]  cmd_addr = '0;
  logic        cmd_ready, done, err, busy, si_out, buf_wren;
  logic [3:0]  buf_addr;
  logic [31:0] buf_wdata, buf_rdata;

  logic [31:0] mem [16];
  logic [31:0] pat [16];
  logic [35:0] rdq [$];
  logic [31:0] wrq [$];
  logic        doneq [$];
  logic [35:0] mon_e;
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  si_pif_master #(.ACK_TIMEOUT(100)) dut (
    .clk(clk), .reset_l(reset_l), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_addr(cmd_addr), .done(done), .err(err), .busy(busy),
    .si_out(si_out), .si_in(si_in), .buf_addr(buf_addr), .buf_wren(buf_wren),
    .buf_wdata(buf_wdata), .buf_rdata(buf_rdata)
  );

  always @(posedge clk) buf_rdata <= mem[buf_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (buf_wren) begin
      if (rdq.size() == 0) chk("wren_unexpected", 32'd1, 32'd0);
      else begin
        mon_e = rdq.pop_front();
        chk("wren_addr", 32'(buf_addr), 32'(mon_e[35:32]));
        chk("wren_data", buf_wdata, mon_e[31:0]);
      end
    end
    if (done) begin
      if (doneq.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
      else chk("done_err", 32'(err), 32'(doneq.pop_front()));
    end
  end

  task automatic issue(input logic [1:0] t, input logic [8:0] a);
    logic [10:0] req;
    req = '0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_type = t; cmd_addr = a;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("start_bit", 32'(si_out), 32'd0);
    chk("busy_start", 32'(busy), 32'd1);
    for (int i = 0; i < CMD_BITS; i++) begin
      @(negedge clk);
      req = {req[9:0], si_out};
    end
    chk("req_bits", 32'(req), 32'({t, a}));
  endtask

  task automatic pif_read(input int nw, input int abort_at);
    repeat (2) @(negedge clk);
    si_in = 1'b0;
    for (int i = 0; i < 32 * nw; i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        #2 reset_l = 1'b0;
        #1;
        si_in = 1'b1;
        chk("rst_si_out", 32'(si_out), 32'd1);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_words_left", 32'(rdq.size()), 32'd10);
        chk("rst_done_left", 32'(doneq.size()), 32'd1);
        rdq.delete();
        doneq.delete();
        repeat (2) @(negedge clk);
        reset_l = 1'b1;
        return;
      end
      si_in = pat[i / 32][31 - i % 32];
    end
    @(negedge clk);
    si_in = 1'b1;
  endtask

  task automatic pif_write(input int nw);
    int n;
    logic [31:0] w;
    w = '0;
    repeat (2) @(negedge clk);
    si_in = 1'b0;
    @(negedge clk);
    si_in = 1'b1;
    n = 0;
    while (si_out !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wr_start_bit", 32'(si_out), 32'd0);
    for (int k = 0; k < nw; k++) begin
      for (int b = 0; b < 32; b++) begin
        @(negedge clk);
        w = {w[30:0], si_out};
      end
      chk("wr_word", w, wrq.size() != 0 ? wrq.pop_front() : 32'hDEAD_BEEF);
    end
    @(negedge clk);
    chk("wr_done_after_last", 32'(done), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!cmd_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_flags", {24'd0, si_out, cmd_ready, done, err, busy, buf_wren, 2'b0}, {24'd0, 8'b1100_0000});
    chk("reset_addr", 32'(buf_addr), 32'd0);
    chk("reset_wdata", buf_wdata, 32'd0);
    reset_l = 1'b1;
    pat[0] = 32'hA5C3_0F81;
    rdq.push_back({4'd0, pat[0]});
    doneq.push_back(1'b0);
    issue(SI_RD4, 9'h1F0);
    pif_read(1, -1);
    wait_idle(50);
    mem[0] = 32'h1234_5678;
    wrq.push_back(mem[0]);
    doneq.push_back(1'b0);
    issue(SI_WR4, 9'h001);
    pif_write(1);
    wait_idle(10);
    for (int i = 0; i < 16; i++) begin
      mem[i] = 32'h0101_0101 * i;
      wrq.push_back(mem[i]);
    end
    doneq.push_back(1'b0);
    issue(SI_WR64, 9'h0AA);
    pif_write(16);
    wait_idle(10);
    for (int i = 0; i < 16; i++) begin
      pat[i] = i;
      rdq.push_back({i[3:0], pat[i]});
    end
    doneq.push_back(1'b0);
    issue(SI_RD64, 9'h155);
    pif_read(16, -1);
    wait_idle(50);
    for (int i = 0; i < 16; i++) begin
      pat[i] = $urandom;
      rdq.push_back({i[3:0], pat[i]});
    end
    doneq.push_back(1'b0);
    issue(SI_RD64, 9'h003);
    pif_read(16, 200);
    pat[0] = 32'h5A3C_96E1;
    rdq.push_back({4'd0, pat[0]});
    doneq.push_back(1'b0);
    issue(SI_RD4, 9'h0F0);
    pif_read(1, -1);
    wait_idle(50);
`ifdef SI_TIMEOUT_EN
    doneq.push_back(1'b1);
    issue(SI_RD4, 9'h010);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 300);
    chk("timeout_cycles", 32'(n), 32'd101);
    wait_idle(10);
`else
    issue(SI_RD4, 9'h010);
    repeat (200) @(negedge clk);
    chk("stuck_busy", 32'(busy), 32'd1);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_ignores_cmd", 32'(cmd_ready), 32'd0);
    #2 reset_l = 1'b0;
    @(negedge clk);
    reset_l = 1'b1;
    chk("recover_ready", 32'(cmd_ready), 32'd1);
`endif
    repeat (5) @(negedge clk);
    chk("rd_queue_empty", 32'(rdq.size()), 32'd0);
    chk("wr_queue_empty", 32'(wrq.size()), 32'd0);
    chk("done_queue_empty", 32'(doneq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/si_pif_master.md
Name: si_pif_master

Overview:
- RCP-side serial initiator for the PIF serial link. It is the opposite end of the PIF responder.
- Accepts one command at a time from a host: a 2-bit transfer type and a 9-bit PIF word address.
- Serialises the request onto si_out, waits for the PIF acknowledge on si_in, then either receives or transmits 4 or 64 bytes through a 16x32 word-buffer port.
- Used as the RCP-side model in system benches and as the SI master in FPGA bring-up builds without a real RCP.

Parameters:
- ACK_TIMEOUT, 4095: clk cycles to wait for the PIF acknowledge before aborting. Only used when SI_TIMEOUT_EN is defined.
- TO_W, 12: width of the timeout counter. ACK_TIMEOUT must be less than 2^TO_W.

Ports:
- clk  in  1  system clock; si_out and si_in are both in this domain.
- reset_l  in  1  asynchronous active-low reset.
- cmd_valid  in  1  host command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_type  in  2  0=write64B, 1=read64B, 2=write4B, 3=read4B.
- cmd_addr  in  9  PIF word address.
- done  out  1  one-cycle pulse when a transfer completes or aborts.
- err  out  1  valid with done; 1 = ack timeout.
- busy  out  1  high whenever the FSM is not in IDLE.
- si_out  out  1  serial line to the PIF; idles high.
- si_in  in  1  serial line from the PIF; asynchronous to clk.
- buf_addr  out  4  word index into the host buffer.
- buf_wren  out  1  one-cycle write strobe for received words.
- buf_wdata  out  32  received word.
- buf_rdata  in  32  word to transmit; synchronous read, valid 1 cycle after buf_addr.

Behaviour:
- Reset (asynchronous, reset_l low): clk and reset_l are fixed as stated in Ports.
  - si_out=1, state IDLE, cmd_ready=1.
  - done=0, err=0, busy=0, buf_wren=0, buf_addr=0, buf_wdata=0.
  - Reset asserted mid-transfer abandons the transfer immediately. No done pulse is produced.
- si_in input: passed through a 2-flop synchroniser, giving si_s. A falling edge is defined as si_s=0 with the previous si_s=1.
- Nwords: 16 for types 0/1, 1 for types 2/3. buf_addr counts 0..Nwords-1 and never wraps within a transfer.
- IDLE:
  - si_out=1.
  - On cmd_valid & cmd_ready: latch type and addr, go to START.
  - cmd_valid while busy is ignored, not queued.
- START: one cycle with si_out=0.
- CMD: 11 cycles driving type[1], type[0], addr[8]..addr[0], MSB first, one bit per clk. Then si_out=1 and go to ACK_WAIT.
- ACK_WAIT:
  - si_out=1; wait for a falling edge on si_s.
  - On the edge, set buf_addr=0. Read types go to RD_DATA; write types go to WR_START.
- RD_DATA:
  - 32*Nwords cycles. Each cycle shifts si_s into the receive shifter, MSB first.
  - On the 32nd bit of each word: buf_wren=1, buf_wdata=the assembled word, buf_addr=word index. Then buf_addr increments, except after the last word.
  - After the last word, go to DONE.
- WR_START:
  - The transmit shifter loads buf_rdata (word 0).
  - si_out=0 for one cycle; this is the write start bit.
- WR_DATA:
  - 32*Nwords cycles driving the shifter MSB first.
  - buf_addr advances to w+1 two bit-cycles before the last bit of word w. buf_rdata is loaded in the last-bit cycle, so there are no gaps between words.
  - After the last bit, go to DONE.
- DONE:
  - One cycle: si_out=1, done=1, err=0. Then go to IDLE.
  - cmd_ready returns high the cycle after done.
- Timing: cmd_valid to the first si_out low is 1 cycle. The request is 12 cycles long (start bit plus 11 command bits).
- Simultaneous events: a si_in falling edge during START or CMD is ignored. Ack detection is only armed in ACK_WAIT.

Optional Feature:
- SI_TIMEOUT_EN defined:
  - ACK_WAIT counts clk cycles.
  - After ACK_TIMEOUT cycles without a falling edge, go to DONE with done=1, err=1. No buffer writes occur.
- SI_TIMEOUT_EN undefined:
  - ACK_WAIT waits indefinitely.
  - err is tied to 0 and no counter is synthesised.

Decomposition:
- Package si_pif_pkg holds:
  - transfer-type constants: SI_WR64=0, SI_RD64=1, SI_WR4=2, SI_RD4=3;
  - the state enum: IDLE, START, CMD, ACK_WAIT, RD_DATA, WR_START, WR_DATA, DONE;
  - the constants CMD_BITS=11 and WORD_BITS=32.
- Sub-module si_sync2: the 2-flop synchroniser, also reusable on the PIF side.

Test Plan:
- Read4B, type=3, addr=0x1F0; PIF model returns 0xA5C3_0F81 -> si_out shows start bit then 11'b11_111110000. Expect one buf_wren with buf_addr=0 and buf_wdata=0xA5C3_0F81, then done=1, err=0.
- Write4B, type=2, addr=0x001, buf[0]=0x1234_5678 -> after the ack, si_out shows one low start bit then 0x12345678 MSB first. Expect done=1.
- Write64B, buf[i]=0x0101_0101*i -> 512 contiguous bits with no gap cycles. The PIF model captures all 16 words exactly.
- Read64B with incrementing pattern 0..15 -> 16 buf_wren pulses, buf_addr 0..15, data matching the pattern, then done=1.
- SI_TIMEOUT_EN with ACK_TIMEOUT=100 and si_in held high -> done=1, err=1 at 100 cycles after ACK_WAIT entry, no buf_wren. Without the macro the FSM stays busy.
- reset_l pulsed low at bit 200 of a Read64B -> si_out=1 and cmd_ready=1 immediately, no done pulse. The next Read4B completes normally.
